// File: rtl/zion_clr_pipe_slice_pkg.sv
// Shared types and helpers for the clearable two-entry pipeline slice.
package zion_clr_pipe_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slice_state_e;

    localparam int FLUSH_CNT_W = 16;

    // Adds a discarded-beat count to the flush counter, sticking at all-ones.
    function automatic logic [FLUSH_CNT_W-1:0] sat_add_lvl(
        input logic [FLUSH_CNT_W-1:0] cnt,
        input logic [1:0]             lvl
    );
        logic [FLUSH_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(FLUSH_CNT_W-1){1'b0}}, lvl};
        if (sum[FLUSH_CNT_W]) begin
            return {FLUSH_CNT_W{1'b1}};
        end else begin
            return sum[FLUSH_CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/zion_clr_pipe_slice_ent.sv
// One storage entry of the pipeline slice: load enable, synchronous clear
// to the idle value, asynchronous active-high reset.
module zion_clr_pipe_slice_ent
    import zion_clr_pipe_slice_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] dat_r;

    // Entry register; clear beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_r <= INI_DATA;
        end else if (clr) begin
            dat_r <= INI_DATA;
        end else if (ld) begin
            dat_r <= d;
        end else begin
            dat_r <= dat_r;
        end
    end

    assign q = dat_r;

endmodule

// File: rtl/zion_basic_circuit_lib_clr_pipe_slice.sv
// Two-entry valid/ready skid slice with synchronous flush (iClr).
// Optional flush counter output enabled by ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN.
module zion_basic_circuit_lib_clr_pipe_slice
    import zion_clr_pipe_slice_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [1:0]       oLvl
`ifdef ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN
    ,
    output logic [FLUSH_CNT_W-1:0] oFlushCnt
`endif
);

    if (WIDTH < 1) begin : g_width_chk
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_clr_pipe_slice: WIDTH must be >= 1");
`else
        $error("zion_basic_circuit_lib_clr_pipe_slice: WIDTH must be >= 1");
`endif
    end

    slice_state_e     state_r;
    slice_state_e     state_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             m_ld_s;
    logic             s_ld_s;
    logic [WIDTH-1:0] m_d_s;
    logic [WIDTH-1:0] s_d_s;
    logic [WIDTH-1:0] m_q_s;
    logic [WIDTH-1:0] s_q_s;

    // Handshake flags depend only on the state register, never on iVld/iRdy.
    assign oVld   = (state_r != EMPTY);
    assign oRdy   = (state_r != TWO);
    assign oLvl   = state_r;
    assign oDat   = m_q_s;
    assign push_s = iVld & oRdy;
    assign pop_s  = oVld & iRdy;

    // Next state and entry load selection.
    always_comb begin
        state_nxt_s = state_r;
        m_ld_s      = 1'b0;
        s_ld_s      = 1'b0;
        m_d_s       = iDat;
        s_d_s       = iDat;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ONE;
                    m_ld_s      = 1'b1;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && !pop_s) begin
                    state_nxt_s = TWO;
                    s_ld_s      = 1'b1;
                end else if (pop_s && !push_s) begin
                    state_nxt_s = EMPTY;
                    m_ld_s      = 1'b1;
                    m_d_s       = INI_DATA;
                end else if (push_s && pop_s) begin
                    m_ld_s      = 1'b1;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            TWO: begin
                // Skid entry advances into main; upstream is stalled here.
                if (pop_s) begin
                    state_nxt_s = ONE;
                    m_ld_s      = 1'b1;
                    m_d_s       = s_q_s;
                    s_ld_s      = 1'b1;
                    s_d_s       = INI_DATA;
                end else begin
                    state_nxt_s = TWO;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State register; flush overrides any same-cycle push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else if (iClr) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    zion_clr_pipe_slice_ent #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .clr (iClr),
        .ld  (m_ld_s),
        .d   (m_d_s),
        .q   (m_q_s)
    );

    zion_clr_pipe_slice_ent #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (iClr),
        .ld  (s_ld_s),
        .d   (s_d_s),
        .q   (s_q_s)
    );

`ifdef ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN
    logic [FLUSH_CNT_W-1:0] flush_cnt_r;

    // Accumulates beats thrown away by flushes; survives iClr itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= {FLUSH_CNT_W{1'b0}};
        end else if (iClr) begin
            flush_cnt_r <= sat_add_lvl(flush_cnt_r, oLvl);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign oFlushCnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_zion_basic_circuit_lib_clr_pipe_slice.sv
// Self-checking bench: queue model compared every cycle plus directed literals.
module tb_zion_basic_circuit_lib_clr_pipe_slice;

    localparam logic [7:0] INI = 8'h5A;

    logic       clk;
    logic       rst;
    logic       iClr;
    logic       iVld;
    logic       oRdy;
    logic [7:0] iDat;
    logic       oVld;
    logic       iRdy;
    logic [7:0] oDat;
    logic [1:0] oLvl;
`ifdef ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN
    logic [15:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       acc_last;
    logic [7:0] seq;

    zion_basic_circuit_lib_clr_pipe_slice #(
        .WIDTH    (8),
        .INI_DATA (INI)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .iClr (iClr),
        .iVld (iVld),
        .oRdy (oRdy),
        .iDat (iDat),
        .oVld (oVld),
        .iRdy (iRdy),
        .oDat (oDat),
        .oLvl (oLvl)
`ifdef ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN
        ,
        .oFlushCnt (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            acc_last <= 1'b0;
        end else begin
            automatic bit m_vld  = (mq.size() != 0);
            automatic bit m_rdy  = (mq.size() != 2);
            automatic bit m_push = iVld && m_rdy;
            automatic bit m_pop  = m_vld && iRdy;
            acc_last <= m_push;
            if (iClr) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(iDat);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_vld", {31'd0, oVld}, {31'd0, (mq.size() != 0)});
        chk("model_rdy", {31'd0, oRdy}, {31'd0, (mq.size() != 2)});
        chk("model_lvl", {30'd0, oLvl}, mq.size());
        chk("model_dat", {24'd0, oDat}, {24'd0, (mq.size() != 0) ? mq[0] : INI});
    end

    initial begin
        rst  = 1'b1;
        iClr = 1'b0;
        iVld = 1'b0;
        iRdy = 1'b0;
        iDat = 8'h00;
        seq  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_vld", {31'd0, oVld}, 32'd0);
        chk("rst_rdy", {31'd0, oRdy}, 32'd1);
        chk("rst_dat", {24'd0, oDat}, {24'd0, INI});
        chk("rst_lvl", {30'd0, oLvl}, 32'd0);
`ifdef ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN
        chk("rst_fcnt", {16'd0, flush_cnt}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Streaming at full rate.
        iVld = 1'b1;
        iRdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            iDat = 8'(i);
            @(negedge clk);
            chk("stream_dat", {24'd0, oDat}, i);
            chk("stream_vld", {31'd0, oVld}, 32'd1);
            chk("stream_lvl", {30'd0, oLvl}, 32'd1);
        end
        iVld = 1'b0;
        @(negedge clk);
        chk("stream_drain_lvl", {30'd0, oLvl}, 32'd0);

        // Backpressure fills both entries.
        iRdy = 1'b0;
        iVld = 1'b1;
        iDat = 8'hA1;
        @(negedge clk);
        iDat = 8'hA2;
        @(negedge clk);
        chk("bp_lvl2", {30'd0, oLvl}, 32'd2);
        chk("bp_rdy0", {31'd0, oRdy}, 32'd0);
        chk("bp_dat_a1", {24'd0, oDat}, 32'hA1);
        iVld = 1'b0;
        iRdy = 1'b1;
        @(negedge clk);
        chk("bp_dat_a2", {24'd0, oDat}, 32'hA2);
        chk("bp_lvl1", {30'd0, oLvl}, 32'd1);
        @(negedge clk);
        chk("bp_lvl0", {30'd0, oLvl}, 32'd0);
        chk("bp_dat_ini", {24'd0, oDat}, {24'd0, INI});

        // Flush while full, with a push and pop offered in the same cycle.
        iRdy = 1'b0;
        iVld = 1'b1;
        iDat = 8'h10;
        @(negedge clk);
        iDat = 8'h11;
        @(negedge clk);
        chk("clr_pre_lvl", {30'd0, oLvl}, 32'd2);
        iClr = 1'b1;
        iDat = 8'h12;
        iRdy = 1'b1;
        chk("clr_cycle_rdy", {31'd0, oRdy}, 32'd0);
        @(negedge clk);
        iClr = 1'b0;
        iVld = 1'b0;
        chk("clr_vld", {31'd0, oVld}, 32'd0);
        chk("clr_lvl", {30'd0, oLvl}, 32'd0);
        chk("clr_dat", {24'd0, oDat}, {24'd0, INI});
`ifdef ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN
        chk("clr_fcnt", {16'd0, flush_cnt}, 32'd2);
`endif
        @(negedge clk);
        chk("clr_no_12", {31'd0, oVld}, 32'd0);

        // Asynchronous reset between clock edges.
        iVld = 1'b1;
        iRdy = 1'b0;
        iDat = 8'h33;
        @(negedge clk);
        iVld = 1'b0;
        chk("arst_pre_lvl", {30'd0, oLvl}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", {31'd0, oVld}, 32'd0);
        chk("arst_dat", {24'd0, oDat}, {24'd0, INI});
        chk("arst_lvl", {30'd0, oLvl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random handshakes; iDat held until accepted.
        for (int c = 0; c < 10000; c++) begin
            if (!iVld || acc_last) begin
                iVld = ($urandom_range(0, 1) == 1);
                if (iVld) begin
                    iDat = seq;
                    seq  = seq + 8'd1;
                end
            end
            iRdy = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        iVld = 1'b0;
        iRdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rand_drained", {30'd0, oLvl}, 32'd0);

`ifdef ZION_CLR_PIPE_SLICE_FLUSH_CNT_EN
        // Flush counter saturation.
        iRdy = 1'b0;
        iVld = 1'b1;
        iDat = 8'h01;
        @(negedge clk);
        iDat = 8'h02;
        @(negedge clk);
        iVld = 1'b0;
        force dut.flush_cnt_r = 16'hFFFE;
        #1 release dut.flush_cnt_r;
        iClr = 1'b1;
        @(negedge clk);
        iClr = 1'b0;
        chk("sat_fcnt_1", {16'd0, flush_cnt}, 32'hFFFF);
        iVld = 1'b1;
        iDat = 8'h03;
        @(negedge clk);
        iDat = 8'h04;
        @(negedge clk);
        iVld = 1'b0;
        iClr = 1'b1;
        @(negedge clk);
        iClr = 1'b0;
        chk("sat_fcnt_2", {16'd0, flush_cnt}, 32'hFFFF);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
